// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_pkg: shared types and constants for the FIFO-fed UART transmitter.
//   tx_state_t   - transmitter FSM encoding (PARITY is only reached when the
//                  FIFO_UART_TX_PARITY_EN build option is defined)
//   *_DEFAULT    - default CLK_DIV / STOP_BITS
//   frame_cycles - clk cycles per complete frame for a given configuration
package fifo_uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

   localparam int CLK_DIV_DEFAULT   = 16;
   localparam int STOP_BITS_DEFAULT = 1;

   function automatic int frame_cycles(input int bits, input int clk_div,
                                       input int stop_bits, input bit parity);
      return (1 + bits + (parity ? 1 : 0) + stop_bits) * clk_div;
   endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read side of the zero-latency look-ahead FIFO.
//   fifo_not_empty - FIFO holds a word (may be combinational from its write)
//   fifo_data      - look-ahead word, valid while fifo_not_empty is high
//   fifo_shift_out - one-cycle pop strobe from the reader
// Handshake: a word transfers in every cycle where fifo_not_empty and
// fifo_shift_out are both high at the rising edge; the reader never raises
// fifo_shift_out unless fifo_not_empty is high in that same cycle.
// Modports: master = FIFO side, slave = reader side.
interface fifo_uart_tx_if #(parameter int bits = 8);

   logic            fifo_not_empty;
   logic [bits-1:0] fifo_data;
   logic            fifo_shift_out;

   modport master (output fifo_not_empty, output fifo_data, input fifo_shift_out);
   modport slave  (input fifo_not_empty, input fifo_data, output fifo_shift_out);

endinterface

// File: rtl/fifo_uart_tx_baud_tick.sv
// uart_baud_tick: free-running divide-by-CLK_DIV counter.
//   clk, reset - system clock, async active-high reset
//   restart    - synchronous: counter is 0 in the next cycle
//   tick       - high in the last cycle of each CLK_DIV-cycle period
module uart_baud_tick #(
   parameter int CLK_DIV = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (restart || (cnt_q == LAST)) cnt_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a zero-latency look-ahead FIFO onto a UART line.
//   clk, reset - system clock, async active-high reset
//   fifo       - FIFO read side (slave modport of fifo_uart_tx_if)
//   txd        - registered serial output, idle high
//   busy       - high from the pop cycle through the last stop-bit cycle
//   tx_done    - one-cycle pulse in the cycle after the last stop-bit cycle
//   dbg_state  - current FSM state
// Build option FIFO_UART_TX_PARITY_EN adds an even-parity bit after the data.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int bits      = 8,
   parameter int CLK_DIV   = CLK_DIV_DEFAULT,
   parameter int STOP_BITS = STOP_BITS_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   fifo_uart_tx_if.slave    fifo,
   output logic             txd,
   output logic             busy,
   output logic             tx_done,
   output tx_state_t        dbg_state
);

   localparam int            BW        = (bits > 1) ? $clog2(bits) : 1;
   localparam logic [BW-1:0] LAST_BIT  = BW'(bits - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   tx_state_t       state_q, state_d;
   logic [bits-1:0] shreg_q, shreg_d;
   logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
   logic            txd_q, txd_d;
   logic            tx_done_q, tx_done_d;
   logic            pop, tick, restart;
`ifdef FIFO_UART_TX_PARITY_EN
   logic            parity_q, parity_d;
`endif

   // Every state change restarts the bit period so each period is exactly
   // CLK_DIV cycles regardless of where the free-running count was.
   assign restart = (state_d != state_q);

   uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .tick    (tick)
   );

   always_comb begin
      pop       = (state_q == IDLE) && fifo.fifo_not_empty && !reset;
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      tx_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pop) begin
               state_d = START;
               shreg_d = fifo.fifo_data;
            end
         end
         START: if (tick) state_d = DATA;
         DATA: begin
            if (tick) begin
               shreg_d = shreg_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: if (tick) state_d = STOP;
`endif
         STOP: begin
            if (tick) begin
               if (bit_cnt_q == LAST_STOP) begin
                  state_d   = IDLE;
                  tx_done_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // The bit counter is shared by DATA and STOP; each starts counting at 0.
      if (state_d != state_q) bit_cnt_d = '0;
   end

`ifdef FIFO_UART_TX_PARITY_EN
   // Parity is taken from the look-ahead word at pop time.
   always_comb begin
      parity_d = parity_q;
      if (pop) parity_d = ^fifo.fifo_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) parity_q <= 1'b0;
      else       parity_q <= parity_d;
   end
`endif

   // txd is decoded from the next state so the registered line lines up
   // exactly with state_q (first start-bit cycle is the cycle after the pop).
   always_comb begin
      txd_d = 1'b1;
      case (state_d)
         START:  txd_d = 1'b0;
         DATA:   txd_d = shreg_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: txd_d = parity_d;
`endif
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         txd_q     <= 1'b1;
         tx_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         txd_q     <= txd_d;
         tx_done_q <= tx_done_d;
      end
   end

   assign fifo.fifo_shift_out = pop;
   assign txd                 = txd_q;
   assign tx_done             = tx_done_q;
   assign busy                = (state_q != IDLE) || pop;
   assign dbg_state           = state_q;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Consumer-side reader for the team's zero-latency look-ahead FIFO (shift_in/shift_out, fifo_not_empty, look-ahead data).
- Pops one word at a time when the FIFO reports data and serializes it as asynchronous UART (start, data LSB-first, optional parity, stop) on txd.
- Sits between a byte-producing FIFO and the board's serial pin; this is the drain for transmit buffering.

Parameters:
- bits, 8, data word width; must match the FIFO width.
- CLK_DIV, 16, clk cycles per UART bit; legal range >= 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- fifo_not_empty  in  1  FIFO has a word; may be combinational from FIFO shift_in.
- fifo_data  in  bits  FIFO look-ahead output word, valid while fifo_not_empty is high.
- fifo_shift_out  out  1  one-cycle pop strobe to the FIFO's shift_out.
- txd  out  1  serial line, idle high.
- busy  out  1  high from the pop cycle through the last stop-bit cycle.
- tx_done  out  1  one-cycle pulse in the cycle after the final stop-bit cycle.

Behaviour:
- Reset: asynchronous, active-high, one clock domain.
  - Reset values: state=IDLE, txd=1, busy=0, tx_done=0, fifo_shift_out=0, counters=0, shift register=0.
  - Reset mid-frame: txd returns to 1 immediately and the in-flight word is discarded. No pop is issued while reset is high.
- States: IDLE, START, DATA, PARITY (only when the option is enabled), STOP.
- Pop (combinational):
  - fifo_shift_out = (state==IDLE) && fifo_not_empty && !reset.
  - In that same cycle, fifo_data is latched into the shift register and the state moves to START.
  - Zero-latency consequence: a word written into an empty FIFO can be popped in the same cycle it is written.
- Never pop outside IDLE. This guarantees at most one pop per frame; the FIFO must never see shift_out while empty.
- Baud counter:
  - Width $clog2(CLK_DIV); counts 0..CLK_DIV-1.
  - Reloads to 0 on every state entry. Tick = (count==CLK_DIV-1).
  - Each bit period is exactly CLK_DIV cycles.
- START: txd=0 for one bit period, then go to DATA.
- DATA:
  - txd = shift register bit 0; shift right on each tick.
  - Bit counter has width $clog2(bits) or 1 if bits==1. After bits periods, go to PARITY or STOP.
- STOP: txd=1 for STOP_BITS bit periods, then go to IDLE and pulse tx_done for one cycle.
- txd is registered. The first start-bit cycle is the cycle after the pop.
- Frame length is (1 + bits + parity + STOP_BITS) * CLK_DIV cycles.
- Back-to-back transmission: if fifo_not_empty is high on return to IDLE, the pop occurs in that IDLE cycle.
  - The next start bit follows one clk later.
  - Minimum inter-frame gap is 1 clk of idle-high line.
- busy = (state!=IDLE) || fifo_shift_out.
- fifo_not_empty dropping outside IDLE has no effect.
- fifo_data changing after the pop has no effect, because the word is already latched.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined: PARITY state is inserted after DATA for one bit period; txd = XOR of the latched word (even parity). The parity value is computed at pop time from fifo_data.
- Undefined: no PARITY state and no parity logic; the frame goes DATA -> STOP.

Decomposition:
- Package fifo_uart_pkg contains:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam defaults for CLK_DIV and STOP_BITS.
  - function frame_cycles(bits, clk_div, stop_bits, parity) used by the bench.
- One sub-module: uart_baud_tick. It holds the CLK_DIV counter with an async reset, a synchronous restart input and a tick output, and is reused by the future receiver.

Test Plan (bits=8, CLK_DIV=4, STOP_BITS=1, parity off unless stated):
- Reset hold, fifo_not_empty=1 -> fifo_shift_out=0, txd=1, busy=0 for the whole reset; the first pop occurs in the first cycle after reset deassertion.
- Single word 0xA5 -> one fifo_shift_out pulse. txd per 4-clk period: 0,1,0,1,0,0,1,0,1,1. tx_done pulses 40 clks after the first start-bit cycle.
- Three words 0x00,0xFF,0x3C preloaded -> exactly 3 pops, three frames, 1-clk idle gap between frames, 3 tx_done pulses. The third frame's data bits are 0,0,1,1,1,1,0,0.
- Empty FIFO with same-cycle write of 0x81 (zero-latency path) -> pop in the same cycle as the write. The frame carries 0x81: data bits 1,0,0,0,0,0,0,1.
- Reset asserted in DATA bit 3 of 0xF0 -> txd=1 asynchronously, state IDLE, no tx_done. A new word 0x55 then transmits a full correct frame.
- FIFO_UART_TX_PARITY_EN defined, words 0xA5 and 0x07 -> 11-bit frames of 44 clks; parity bit is 0 for 0xA5 and 1 for 0x07.
